// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetcher with epoch-tagged memory pipe and DEPTH-entry FIFO
module instr_prefetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MEM_LAT  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  output logic [31:0]                mem_raddr_o,
  output logic                       mem_req_o,
  input  logic [ILEN-1:0]            mem_rdata_i,
  input  logic                       redirect_valid_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [ILEN-1:0]            instr_o,
  output logic [XLEN-1:0]            instr_pc_o,
  output logic                       fetch_fault_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = $clog2(DEPTH + MEM_LAT + 1) + 1;

  logic [XLEN-1:0] fpc_q;
  logic            fault_q;
  logic            epoch_q;
  logic [MEM_LAT-1:0] pv_q;
  logic [MEM_LAT-1:0] pe_q;
  logic [XLEN-1:0] ppc_q [MEM_LAT];
  logic [ILEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pcs_q [DEPTH];
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   wr_q;
  logic [OW-1:0]   occ_q;
  logic [CW-1:0]   inflight;
  logic            issue;
  logic            push;
  logic            pop;

  // Only current-epoch requests hold a credit; stale ones will be dropped on return.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + CW'(pv_q[i] && (pe_q[i] == epoch_q));
  end

  assign issue         = rst_ni && !fault_q && !redirect_valid_i && ((CW'(occ_q) + inflight) < CW'(DEPTH));
  assign push          = pv_q[MEM_LAT-1] && (pe_q[MEM_LAT-1] == epoch_q) && !redirect_valid_i;
  assign pop           = instr_valid_o && instr_ready_i && !redirect_valid_i;
  assign mem_req_o     = issue;
  assign mem_raddr_o   = fpc_q[31:0];
  assign instr_valid_o = occ_q != '0;
  assign instr_o       = instr_valid_o ? data_q[rd_q] : '0;
  assign instr_pc_o    = instr_valid_o ? pcs_q[rd_q] : '0;
  assign fetch_fault_o = fault_q;
  assign occupancy_o   = occ_q;

  // Fetch PC, alignment fault and epoch; a redirect overrides sequential advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpc_q   <= RESET_PC;
      fault_q <= 1'b0;
      epoch_q <= 1'b0;
    end else if (redirect_valid_i) begin
      fpc_q   <= redirect_pc_i;
      fault_q <= |redirect_pc_i[1:0];
      epoch_q <= ~epoch_q;
    end else if (issue) begin
      fpc_q   <= fpc_q + XLEN'(4);
    end
  end

  // In-flight pipe tracking {valid, epoch, pc} of each outstanding read until its data returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) ppc_q[i] <= '0;
    end else begin
      pv_q[0]  <= issue;
      pe_q[0]  <= epoch_q;
      ppc_q[0] <= fpc_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pe_q[i]  <= pe_q[i-1];
        ppc_q[i] <= ppc_q[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else if (redirect_valid_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      occ_q <= occ_q + OW'(push) - OW'(pop);
    end
  end

  // FIFO storage; contents need no reset because the head is gated by instr_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_q] <= mem_rdata_i;
      pcs_q[wr_q]  <= ppc_q[MEM_LAT-1];
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: scoreboard bench for two prefetcher instances (MEM_LAT 1 and 3)
module tb_instr_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_raddr, a_rdata, a_instr, b_raddr, b_rdata, b_instr;
  logic        a_req, a_redir, a_valid, a_ready, a_fault;
  logic        b_req, b_redir, b_valid, b_ready, b_fault;
  logic [63:0] a_rpc, a_pc, b_rpc, b_pc;
  logic [2:0]  a_occ, b_occ;
  logic [31:0] ra_q, rb1_q, rb2_q, rb3_q;
  logic [63:0] qa [$];
  logic [63:0] qb [$];
  int          total = 0;
  int          bad = 0;
  int          a_pops = 0;
  int          b_pops = 0;

  always #5 clk = ~clk;

  instr_prefetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(4), .MEM_LAT(1), .RESET_PC('0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .mem_raddr_o(a_raddr), .mem_req_o(a_req), .mem_rdata_i(a_rdata),
    .redirect_valid_i(a_redir), .redirect_pc_i(a_rpc), .instr_valid_o(a_valid), .instr_ready_i(a_ready),
    .instr_o(a_instr), .instr_pc_o(a_pc), .fetch_fault_o(a_fault), .occupancy_o(a_occ));

  instr_prefetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(4), .MEM_LAT(3), .RESET_PC('0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .mem_raddr_o(b_raddr), .mem_req_o(b_req), .mem_rdata_i(b_rdata),
    .redirect_valid_i(b_redir), .redirect_pc_i(b_rpc), .instr_valid_o(b_valid), .instr_ready_i(b_ready),
    .instr_o(b_instr), .instr_pc_o(b_pc), .fetch_fault_o(b_fault), .occupancy_o(b_occ));

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory models: return a word derived from the address MEM_LAT cycles later
  always @(posedge clk) begin
    ra_q  <= a_raddr;
    rb1_q <= b_raddr;
    rb2_q <= rb1_q;
    rb3_q <= rb2_q;
  end
  assign a_rdata = word_of(ra_q);
  assign b_rdata = word_of(rb3_q);

  // scoreboard pop side, instance A
  always @(negedge clk) begin
    if (rst_n && a_valid && a_ready && !a_redir) begin
      chk("a_sb_nonempty", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        chk("a_pc", a_pc, qa[0]);
        chk("a_instr", {32'b0, a_instr}, {32'b0, word_of(qa[0][31:0])});
        void'(qa.pop_front());
      end
      a_pops++;
    end
  end

  // scoreboard pop side, instance B
  always @(negedge clk) begin
    if (rst_n && b_valid && b_ready && !b_redir) begin
      chk("b_sb_nonempty", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        chk("b_pc", b_pc, qb[0]);
        chk("b_instr", {32'b0, b_instr}, {32'b0, word_of(qb[0][31:0])});
        void'(qb.pop_front());
      end
      b_pops++;
    end
  end

  task automatic fill_a(input logic [63:0] s);
    qa.delete();
    for (int i = 0; i < 40; i++) qa.push_back(s + 64'(4 * i));
  endtask

  task automatic fill_b(input logic [63:0] s);
    qb.delete();
    for (int i = 0; i < 40; i++) qb.push_back(s + 64'(4 * i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    a_redir = 1'b0;
    b_redir = 1'b0;
    fill_a(64'h0);
    fill_b(64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", a_valid, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_req", a_req, 0);
    chk("rst_fault", a_fault, 0);
    chk("rst_instr", a_instr, 0);
    chk("rst_pc", a_pc, 0);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s, sb, n, w;
    a_rpc = '0;
    b_rpc = '0;
    do_reset();
    // streaming from reset, plus stale-return drop on the long-latency instance
    s = a_pops;
    sb = b_pops;
    a_ready = 1'b1;
    b_ready = 1'b1;
    #1;
    chk("t1_req", a_req, 1);
    chk("t1_addr", a_raddr, 0);
    @(negedge clk);
    chk("t1_valid_c1", a_valid, 0);
    @(negedge clk);
    chk("t1_valid_c2", a_valid, 1);
    @(posedge clk);
    #1;
    b_redir = 1'b1;
    b_rpc = 64'h200;
    fill_b(64'h200);
    @(posedge clk);
    #1 b_redir = 1'b0;
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      chk("t4_no_stale", b_valid, 0);
    end
    @(negedge clk);
    chk("t4_valid", b_valid, 1);
    chk("t4_pc", b_pc, 64'h200);
    repeat (6) @(negedge clk);
    chk("t1_pops", 64'(a_pops - s >= 10), 1);
    chk("t4_pops", 64'(b_pops - sb >= 1), 1);
    // stalled consumer: credit limit then in-order drain
    do_reset();
    s = a_pops;
    n = a_req ? 1 : 0;
    repeat (10) begin
      @(negedge clk);
      if (a_req) n++;
    end
    chk("t2_reqs", 64'(n), 4);
    chk("t2_occ", a_occ, 4);
    chk("t2_req_hold", a_req, 0);
    @(posedge clk);
    #1 a_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("t2_pops", 64'(a_pops - s >= 5), 1);
    // redirect against a full queue with ready asserted
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    s = a_pops;
    a_redir = 1'b1;
    a_rpc = 64'h100;
    a_ready = 1'b1;
    fill_a(64'h100);
    @(negedge clk);
    chk("t3_occ_pre", a_occ, 4);
    chk("t3_req_redir", a_req, 0);
    @(posedge clk);
    #1 a_redir = 1'b0;
    @(negedge clk);
    chk("t3_occ_post", a_occ, 0);
    chk("t3_valid_post", a_valid, 0);
    repeat (6) @(negedge clk);
    chk("t3_pops", 64'(a_pops - s >= 1), 1);
    // misaligned redirect then recovery
    @(posedge clk);
    #1;
    a_redir = 1'b1;
    a_rpc = 64'h102;
    qa.delete();
    @(posedge clk);
    #1 a_redir = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_fault", a_fault, 1);
      chk("t5_req", a_req, 0);
      chk("t5_valid", a_valid, 0);
    end
    @(posedge clk);
    #1;
    a_redir = 1'b1;
    a_rpc = 64'h104;
    fill_a(64'h104);
    @(posedge clk);
    #1 a_redir = 1'b0;
    @(negedge clk);
    chk("t5_fault_clr", a_fault, 0);
    chk("t5_req_resume", a_req, 1);
    s = a_pops;
    repeat (5) @(negedge clk);
    chk("t5_pops", 64'(a_pops - s >= 1), 1);
    // asynchronous reset with a partly filled queue
    @(posedge clk);
    #1 a_ready = 1'b0;
    w = 0;
    while (a_occ != 3 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t6_occ3", a_occ, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", a_valid, 0);
    chk("t6_occ", a_occ, 0);
    chk("t6_req", a_req, 0);
    chk("t6_instr", a_instr, 0);
    chk("t6_pc", a_pc, 0);
    chk("t6_fault", a_fault, 0);
    do_reset();
    s = a_pops;
    chk("t6_addr", a_raddr, 0);
    a_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_pops", 64'(a_pops - s >= 3), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
